phys_reg_free_list: RTL

- Allocator for physical register tags used by the rename map.
- Hands out up to 4 free physical tags per cycle to the rename lanes; these become the map's reserve write data.
- Accepts up to 4 released tags per cycle from commit; these are the previous stable mappings.
- On rewind, returns all speculatively allocated tags by restoring the allocation pointer to the committed pointer.

---
 rtl/phys_reg_free_list_if.sv | 30 +++
 rtl/phys_reg_free_list.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side bus of the physical register free list.
// Signal prefixes are from the free list's point of view; lane k uses bit/element k.
interface phys_reg_free_list_if #(
  parameter int unsigned TAGW = 6
);
  logic                 i_en;
  logic [3:0]           i_reserve;
  logic                 i_reserve_allow;
  logic [3:0][TAGW-1:0] o_new_tag;
  logic                 o_can_reserve;
  logic [3:0]           i_commit;
  logic                 i_commit_allow;
  logic [3:0]           i_release;
  logic [3:0][TAGW-1:0] i_release_tag;
  logic                 i_rewind;
  logic [TAGW:0]        o_free_count;
  logic                 o_error;

  modport master (
    output i_en, i_reserve, i_reserve_allow, i_commit, i_commit_allow,
           i_release, i_release_tag, i_rewind,
    input  o_new_tag, o_can_reserve, o_free_count, o_error
  );

  modport slave (
    input  i_en, i_reserve, i_reserve_allow, i_commit, i_commit_allow,
           i_release, i_release_tag, i_rewind,
    output o_new_tag, o_can_reserve, o_free_count, o_error
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags with speculative/committed heads and rewind.
// Define PHYS_REG_FREE_LIST_CHECK_EN to enable the sticky protocol-error checker.
module phys_reg_free_list #(
  parameter int unsigned NPHYS = 64,
  parameter int unsigned NARCH = 32,
  parameter int unsigned TAGW  = 6
) (
  input logic               i_clk,
  input logic               i_reset,
  phys_reg_free_list_if.slave bus
);

  typedef logic [TAGW:0]   ptr_t;
  typedef logic [TAGW-1:0] tag_t;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  // Number of set lanes strictly below lane k.
  function automatic logic [2:0] prefix4(input logic [3:0] v, input int k);
    logic [3:0] mask;
    mask    = (4'd1 << k) - 4'd1;
    prefix4 = popcnt4(v & mask);
  endfunction

  tag_t r_list [NPHYS];
  ptr_t r_spec_head;
  ptr_t r_commit_head;
  ptr_t r_tail;

  ptr_t            w_spec_head_d;
  ptr_t            w_commit_head_d;
  ptr_t            w_tail_d;
  ptr_t            w_free_count;
  logic            w_can_reserve;
  logic            w_do_res;
  logic [2:0]      w_res_cnt;
  logic [2:0]      w_com_cnt;
  logic [2:0]      w_rel_cnt;
  logic [3:0][2:0] w_res_ofs;
  logic [3:0][2:0] w_rel_ofs;
  tag_t            w_rd_idx [4];
  tag_t            w_wr_idx [4];

  always_comb begin
    w_res_cnt = popcnt4(bus.i_reserve);
    w_com_cnt = popcnt4(bus.i_commit);
    w_rel_cnt = popcnt4(bus.i_release);
    for (int k = 0; k < 4; k++) begin
      w_res_ofs[k] = prefix4(bus.i_reserve, k);
      w_rel_ofs[k] = prefix4(bus.i_release, k);
      w_rd_idx[k]  = r_spec_head[TAGW-1:0] + tag_t'(w_res_ofs[k]);
      w_wr_idx[k]  = r_tail[TAGW-1:0] + tag_t'(w_rel_ofs[k]);
    end
  end

  always_comb begin
    w_free_count  = r_tail - r_spec_head;
    w_can_reserve = (w_free_count >= ptr_t'(4));
  end

  // Offers read registered state only, so same-cycle releases are never bypassed.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.o_new_tag[k] = r_list[w_rd_idx[k]];
    end
    bus.o_can_reserve = w_can_reserve;
    bus.o_free_count  = w_free_count;
  end

  always_comb begin
    w_do_res        = bus.i_en & bus.i_reserve_allow & w_can_reserve & ~bus.i_rewind;
    w_spec_head_d   = r_spec_head;
    w_commit_head_d = r_commit_head;
    w_tail_d        = r_tail;
    if (bus.i_en) begin
      if (bus.i_commit_allow) begin
        w_commit_head_d = r_commit_head + ptr_t'(w_com_cnt);
      end
      w_tail_d = r_tail + ptr_t'(w_rel_cnt);
      if (bus.i_rewind) begin
        w_spec_head_d = w_commit_head_d;
      end else if (w_do_res) begin
        w_spec_head_d = r_spec_head + ptr_t'(w_res_cnt);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < int'(NPHYS); i++) begin
        r_list[i] <= (i < int'(NPHYS - NARCH)) ? tag_t'(int'(NARCH) + i) : '0;
      end
      r_spec_head   <= '0;
      r_commit_head <= '0;
      r_tail        <= ptr_t'(NPHYS - NARCH);
    end else begin
      if (bus.i_en) begin
        for (int k = 0; k < 4; k++) begin
          if (bus.i_release[k]) begin
            r_list[w_wr_idx[k]] <= bus.i_release_tag[k];
          end
        end
      end
      r_spec_head   <= w_spec_head_d;
      r_commit_head <= w_commit_head_d;
      r_tail        <= w_tail_d;
    end
  end

`ifdef PHYS_REG_FREE_LIST_CHECK_EN
  ptr_t        w_free_next;
  ptr_t        w_in_flight;
  logic        w_err_res;
  logic        w_err_com;
  logic        w_err_rel;
  logic        w_err_tag;
  logic        w_err;
  logic        r_error;
  logic [31:0] r_cycle;

  always_comb begin
    w_free_next = w_tail_d - w_spec_head_d;
    w_in_flight = r_spec_head - r_commit_head;
    w_err_res   = bus.i_reserve_allow & (|bus.i_reserve) & ~w_can_reserve;
    w_err_com   = bus.i_commit_allow & (ptr_t'(w_com_cnt) > w_in_flight);
    w_err_rel   = (w_free_next > ptr_t'(NPHYS));
    w_err_tag   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.i_release[k] && (bus.i_release_tag[k] == '0)) begin
        w_err_tag = 1'b1;
      end
    end
    w_err = bus.i_en & (w_err_res | w_err_com | w_err_rel | w_err_tag);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_error <= 1'b0;
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_err) begin
        r_error <= 1'b1;
        $display("phys_reg_free_list: protocol error at cycle %0d", r_cycle);
      end
    end
  end

  assign bus.o_error = r_error;
`else
  assign bus.o_error = 1'b0;
`endif

endmodule
